// File: rtl/negedge_param_updown_counter.sv
// negedge_param_updown_counter
// Parametrised falling-edge up/down counter with parallel load, count enable,
// optional saturation, a combinational terminal-count output for cascading
// and a sticky overflow/underflow flag. Every flop is clocked by the falling
// edge of CLK and reset asynchronously by RST (active high).
//
// Cascade usage: drive the next stage's EN from this stage's TC and share CLK.
// The next stage then advances exactly on the edge where this stage wraps.

module negedge_param_updown_counter #(
    parameter int WIDTH       = 3,
    parameter int MODULUS     = 2 ** WIDTH,
    parameter bit SATURATE    = 1'b0,
    parameter int RESET_VALUE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    // Top of the count range on WIDTH bits. When MODULUS == 2**WIDTH this is
    // all ones, so the truncating cast is exact.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    // MODULUS itself needs one extra bit when it equals 2**WIDTH; the load
    // range check is therefore done on WIDTH+1 bits.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             at_max;
    logic             at_min;
    logic             count_up;
    logic             count_dn;
    logic             end_event;
    logic             d_in_range;
    logic [WIDTH-1:0] load_val;

    // Range-end detection and the qualified count requests.
    always_comb begin
        at_max     = (q_q == MAX_Q);
        at_min     = (q_q == '0);
        count_up   = EN & ~LOAD & UP;
        count_dn   = EN & ~LOAD & ~UP;
        // A wrap or saturate event happens on the edge after TC is high.
        end_event  = (count_up & at_max) | (count_dn & at_min);
        d_in_range = ({1'b0, D} < MOD_EXT);
        // Out-of-range load values clamp to the top of the range.
        load_val   = d_in_range ? D : MAX_Q;
    end

    // Next-count selection: LOAD has priority over EN, otherwise hold.
    always_comb begin
        // NOTE: assign a default first so every path defines q_d; a missing
        // branch would otherwise infer a latch.
        q_d = q_q;
        if (LOAD) begin
            q_d = load_val;
        end else if (count_up) begin
            if (!at_max) begin
                q_d = q_q + ONE_Q;
            end else if (!SATURATE) begin
                q_d = '0;
            end
        end else if (count_dn) begin
            if (!at_min) begin
                q_d = q_q - ONE_Q;
            end else if (!SATURATE) begin
                q_d = MAX_Q;
            end
        end
    end

    // Sticky flag: a wrap/saturate event on the same edge as CLR_OVF wins.
    always_comb begin
        ovf_d = ovf_q;
        if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
        if (end_event) begin
            ovf_d = 1'b1;
        end
    end

    // State registers on the falling edge with asynchronous active-high reset.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            q_q   <= RST_Q;
            ovf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all flop updates so every
            // register samples the pre-edge values regardless of block order.
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // Output mapping; TC is combinational from the current count and inputs.
    always_comb begin
        Q   = q_q;
        OVF = ovf_q;
        TC  = end_event;
    end

endmodule
